// File: rtl/debounce_trigger_if.sv
// Signal bundle for debounce_trigger: raw input towards the conditioner,
// debounced level and single-cycle trigger pulse back out.
interface debounce_trigger_if;
  logic in_i;
  logic level_o;
  logic trig_o;

  modport master (
    output in_i,
    input  level_o,
    input  trig_o
  );

  modport slave (
    input  in_i,
    output level_o,
    output trig_o
  );
endinterface

// File: rtl/debounce_trigger.sv
// Two-flop synchroniser, debounce FSM with 32-bit down-counter and trigger pulse.
// Optional macro DEBOUNCE_TRIGGER_BOTH_EN: pulse on falling commits as well as rising.
module debounce_trigger #(
  parameter int unsigned DEBOUNCE = 20000
) (
  input  logic              clk,
  input  logic              reset,
  debounce_trigger_if.slave bus
);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  // Observation 1 happens in IDLE, so the WAIT count covers the remaining DEBOUNCE-1 samples.
  localparam logic [31:0] CNT_INIT = (DEBOUNCE > 32'd1) ? (DEBOUNCE - 32'd2) : 32'd0;
  localparam bit          INSTANT  = (DEBOUNCE == 32'd1);

  logic        sync1_q;
  logic        sync2_q;
  logic [1:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        trig_q, trig_d;
  logic        commit;
  logic        s;

  assign s = sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= bus.in_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    trig_d  = 1'b0;
    commit  = 1'b0;

    case (state_q)
      IDLE_LO, IDLE_HI: begin
        if (s != level_q) begin
          if (INSTANT) begin
            commit = 1'b1;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = level_q ? WAIT_LO : WAIT_HI;
          end
        end
      end
      WAIT_HI, WAIT_LO: begin
        if (s == level_q) begin
          state_d = level_q ? IDLE_HI : IDLE_LO;
        end else if (cnt_q == 32'd0) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: begin
        state_d = level_q ? IDLE_HI : IDLE_LO;
      end
    endcase

    if (commit) begin
      level_d = s;
      state_d = s ? IDLE_HI : IDLE_LO;
`ifdef DEBOUNCE_TRIGGER_BOTH_EN
      trig_d  = 1'b1;
`else
      trig_d  = s;
`endif
    end
  end

  // Reset wins over a commit landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE_LO;
      cnt_q   <= 32'd0;
      level_q <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      trig_q  <= trig_d;
    end
  end

  assign bus.level_o = level_q;
  assign bus.trig_o  = trig_q;

endmodule

// File: tb/tb_debounce_trigger.sv
// Bench for debounce_trigger: DEBOUNCE=4 and DEBOUNCE=1 instances side by side,
// compared every cycle against a run-length model plus literal edge checks.
module tb_debounce_trigger;

  localparam int DA = 4;
  localparam int DB = 1;
`ifdef DEBOUNCE_TRIGGER_BOTH_EN
  localparam bit BOTH = 1'b1;
`else
  localparam bit BOTH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  debounce_trigger_if ifa ();
  debounce_trigger_if ifb ();

  debounce_trigger #(.DEBOUNCE(DA)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
  debounce_trigger #(.DEBOUNCE(DB)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle_n = 0;
  int dval [2];
  bit p1 [2];
  bit p2 [2];
  bit mlvl [2];
  bit mtrg [2];
  int run [2];
  logic prev_trg_a = 1'b0;

  task automatic check(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0b want=%0b cycle=%0d", name, got, exp, cycle_n);
    end
  endtask

  // Model: a level change is accepted once DEBOUNCE consecutive synchronised
  // samples differ from the current level; the synchronised sample is the
  // input delayed by two clocks.
  task automatic model_step(input bit r, input bit x);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        p1[k] = 1'b0; p2[k] = 1'b0; mlvl[k] = 1'b0; mtrg[k] = 1'b0; run[k] = 0;
      end else begin
        mtrg[k] = 1'b0;
        if (p2[k] != mlvl[k]) begin
          run[k]++;
          if (run[k] >= dval[k]) begin
            mlvl[k] = p2[k];
            mtrg[k] = p2[k] | BOTH;
            run[k]  = 0;
          end
        end else begin
          run[k] = 0;
        end
        p2[k] = p1[k];
        p1[k] = x;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit x);
    rst = r;
    ifa.in_i = x;
    ifb.in_i = x;
    model_step(r, x);
    @(posedge clk);
    #1;
    cycle_n++;
    check("level_a", ifa.level_o, mlvl[0]);
    check("trig_a",  ifa.trig_o,  mtrg[0]);
    check("level_b", ifb.level_o, mlvl[1]);
    check("trig_b",  ifb.trig_o,  mtrg[1]);
    check("trig_a_adjacent", ifa.trig_o & prev_trg_a, 1'b0);
    prev_trg_a = ifa.trig_o;
    $display("cyc %0d rst=%0b in=%0b a:lvl=%0b trg=%0b b:lvl=%0b trg=%0b",
             cycle_n, r, x, ifa.level_o, ifa.trig_o, ifb.level_o, ifb.trig_o);
  endtask

  initial begin
    int pulses;
    bit x;
    int hold;
    bit seq [5];

    dval[0] = DA;
    dval[1] = DB;
    rst = 1'b1;
    ifa.in_i = 1'b0;
    ifb.in_i = 1'b0;

    // Reset, then a clean rising step
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("reset_level_a", ifa.level_o, 1'b0);
    check("reset_trig_a",  ifa.trig_o,  1'b0);
    pulses = 0;
    for (int e = 1; e <= 12; e++) begin
      cyc(1'b0, 1'b1);
      if (ifa.trig_o) pulses++;
      if (e == 3) begin
        check("d1_level_e3", ifb.level_o, 1'b1);
        check("d1_trig_e3",  ifb.trig_o,  1'b1);
      end
      if (e == 4) check("d1_trig_e4", ifb.trig_o, 1'b0);
      if (e == 5) check("step_level_e5", ifa.level_o, 1'b0);
      if (e == 6) begin
        check("step_level_e6", ifa.level_o, 1'b1);
        check("step_trig_e6",  ifa.trig_o,  1'b1);
      end
      if (e == 7) check("step_trig_e7", ifa.trig_o, 1'b0);
    end
    check("step_one_pulse", pulses == 1, 1'b1);

    // Falling step from level 1
    for (int e = 1; e <= 10; e++) begin
      cyc(1'b0, 1'b0);
      if (e == 5) check("fall_level_e5", ifa.level_o, 1'b1);
      if (e == 6) begin
        check("fall_level_e6", ifa.level_o, 1'b0);
        check("fall_trig_e6",  ifa.trig_o,  BOTH);
      end
      if (e == 7) check("fall_trig_e7", ifa.trig_o, 1'b0);
    end

    // Glitch of 3 clocks
    for (int e = 1; e <= 12; e++) begin
      cyc(1'b0, (e <= 3) ? 1'b1 : 1'b0);
      check("glitch_level", ifa.level_o, 1'b0);
      check("glitch_trig",  ifa.trig_o,  1'b0);
    end

    // Bounce 1,0,1,1,0 then held high
    seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, seq[i]);
      check("bounce_no_trig", ifa.trig_o, 1'b0);
    end
    for (int e = 1; e <= 10; e++) begin
      cyc(1'b0, 1'b1);
      check("bounce_trig", ifa.trig_o, (e == 6) ? 1'b1 : 1'b0);
    end

    // Settle low, then reset in the middle of a rising debounce
    for (int e = 1; e <= 10; e++) cyc(1'b0, 1'b0);
    for (int e = 1; e <= 3; e++) cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b1);
    check("midwait_reset_level", ifa.level_o, 1'b0);
    check("midwait_reset_trig",  ifa.trig_o,  1'b0);
    for (int e = 1; e <= 8; e++) begin
      cyc(1'b0, 1'b1);
      if (e == 1) begin
        check("midwait_level_e1", ifa.level_o, 1'b0);
        check("midwait_trig_e1",  ifa.trig_o,  1'b0);
      end
      if (e == 5) check("midwait_trig_e5", ifa.trig_o, 1'b0);
      if (e == 6) begin
        check("midwait_level_e6", ifa.level_o, 1'b1);
        check("midwait_trig_e6",  ifa.trig_o,  1'b1);
      end
    end

    // Random bursts with occasional reset
    x = 1'b0;
    for (int n = 0; n < 300; n++) begin
      x = ~x;
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0, x);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
